// File: rtl/regmap_pkg.sv
// regmap_pkg: shared constants, FSM state type and register address map
// for the regmap_stream register map and its telemetry serializer.
package regmap_pkg;

  localparam int TAG_W          = 4;
  localparam int BEAT_PAYLOAD_W = 60;
  localparam int BEAT_W         = 64;
  localparam int MAX_BEATS      = 15;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tlm_state_e;

  localparam logic [7:0] ADDR_PWM_BASE    = 8'h01;
  localparam logic [7:0] ADDR_ERROR_RESET = 8'h05;
  localparam logic [7:0] ADDR_TGT_PITCH   = 8'h0B;
  localparam logic [7:0] ADDR_MAX_SPEED   = 8'h10;
  localparam logic [7:0] ADDR_KP          = 8'h12;

  // Number of 60-bit beats needed for a snapshot, capped at MAX_BEATS.
  function automatic int tlm_beats(input int bits);
    int b;
    b = (bits + BEAT_PAYLOAD_W - 1) / BEAT_PAYLOAD_W;
    return (b > MAX_BEATS) ? MAX_BEATS : b;
  endfunction

endpackage

// File: rtl/regmap_stream_if.sv
// regmap_stream_if: write bus, readback port and telemetry beat stream.
// master = bridge/sink side, slave = regmap_stream.
interface regmap_stream_if;
  import regmap_pkg::*;

  logic [31:0]       wr_data;
  logic              wr_valid;
  logic [7:0]        rd_addr;
  logic              rd_req;
  logic [31:0]       rd_data;
  logic              rd_valid;
  logic [BEAT_W-1:0] tlm_data;
  logic              tlm_valid;
  logic              tlm_ready;

  modport master (
    output wr_data, wr_valid, rd_addr, rd_req, tlm_ready,
    input  rd_data, rd_valid, tlm_data, tlm_valid
  );

  modport slave (
    input  wr_data, wr_valid, rd_addr, rd_req, tlm_ready,
    output rd_data, rd_valid, tlm_data, tlm_valid
  );

endinterface

// File: rtl/tlm_serializer.sv
// tlm_serializer: latches a telemetry snapshot and sends it MSB-first as
// tagged 64-bit beats over valid/ready; counts captures dropped while busy.
module tlm_serializer
  import regmap_pkg::*;
#(
  parameter int TLM_BITS = 120
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [TLM_BITS-1:0] tlm_in,
  input  logic                tlm_capture,
  output logic [BEAT_W-1:0]   tlm_data,
  output logic                tlm_valid,
  input  logic                tlm_ready,
  output logic                tlm_busy,
  output logic [7:0]          tlm_overrun
);

  localparam int BEATS  = tlm_beats(TLM_BITS);
  localparam int PAD_W  = BEATS * BEAT_PAYLOAD_W;
  localparam int PAD_SH = PAD_W - TLM_BITS;

  tlm_state_e       state_q, state_d;
  logic [PAD_W-1:0] snap_in;
  logic [PAD_W-1:0] snap_p0;
  logic [3:0]       beat_q;
  logic             hs, last_beat, accept;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Left-align the snapshot so the short last beat is zero-padded at the LSB end.
  assign snap_in   = PAD_W'(tlm_in) << PAD_SH;
  assign hs        = (state_q == SEND) && tlm_ready;
  assign last_beat = (beat_q == 4'(BEATS - 1));
  assign accept    = (state_q == IDLE) && tlm_capture;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (tlm_capture)      state_d = SEND;
      SEND: if (hs && last_beat)  state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    tlm_valid = 1'b0;
    tlm_busy  = 1'b0;
    if (state_q == SEND) begin
      tlm_valid = 1'b1;
      tlm_busy  = 1'b1;
    end
  end

  // Beat counter, outgoing beat register and overrun counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q      <= '0;
      tlm_data    <= '0;
      tlm_overrun <= '0;
    end else begin
      if (accept) begin
        beat_q   <= '0;
        tlm_data <= {4'd1, snap_in[PAD_W-1 -: BEAT_PAYLOAD_W]};
      end else if (hs && !last_beat) begin
        beat_q   <= beat_q + 4'd1;
        tlm_data <= {beat_q + 4'd2, snap_p0[PAD_W-1 -: BEAT_PAYLOAD_W]};
      end
      if (tlm_capture && (state_q == SEND))
        tlm_overrun <= sat_inc8(tlm_overrun);
    end
  end

  // Stage p0: remaining beats of the snapshot, top beat next to go out.
  always_ff @(posedge clk) begin
    if (accept)
      snap_p0 <= snap_in << BEAT_PAYLOAD_W;
    else if (hs)
      snap_p0 <= snap_p0 << BEAT_PAYLOAD_W;
  end

endmodule

// File: rtl/regmap_stream.sv
// regmap_stream: parametrised configuration register map with per-register
// write strobes, registered readback and telemetry beat streaming.
// Build option: REGMAP_READBACK_EN enables the readback port; when undefined
// rd_data/rd_valid are tied low and no read mux exists.
module regmap_stream
  import regmap_pkg::*;
#(
  parameter int                         NUM_REGS   = 32,
  parameter int                         DATA_W     = 24,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALS = '0,
  parameter int                         TLM_BITS   = 120
) (
  input  logic                       clk,
  input  logic                       rst,
  regmap_stream_if.slave             bus,
  output logic [NUM_REGS*DATA_W-1:0] regs_q,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       wr_err,
  input  logic [TLM_BITS-1:0]        tlm_in,
  input  logic                       tlm_capture,
  output logic                       tlm_busy,
  output logic [7:0]                 tlm_overrun
);

  logic [7:0] wr_addr;
  logic       wr_addr_ok;

  assign wr_addr    = bus.wr_data[31:24];
  assign wr_addr_ok = (wr_addr != 8'd0) && (int'(wr_addr) < NUM_REGS);

  // Register array and write strobes; address 0 is reserved and never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q    <= RESET_VALS;
      wr_strobe <= '0;
      wr_err    <= 1'b0;
    end else begin
      wr_strobe <= '0;
      wr_err    <= bus.wr_valid && !wr_addr_ok;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (bus.wr_valid && (wr_addr == 8'(i))) begin
          regs_q[i*DATA_W +: DATA_W] <= bus.wr_data[DATA_W-1:0];
          wr_strobe[i]               <= 1'b1;
        end
      end
    end
  end

`ifdef REGMAP_READBACK_EN
  logic [DATA_W-1:0] rd_val;

  // Read mux over the current (pre-write) contents; bad addresses read 0.
  always_comb begin
    rd_val = '0;
    for (int i = 1; i < NUM_REGS; i++)
      if (bus.rd_addr == 8'(i)) rd_val = regs_q[i*DATA_W +: DATA_W];
  end

  // Stage p0: readback result, held while no request is pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
    end else begin
      bus.rd_valid <= bus.rd_req;
      if (bus.rd_req) bus.rd_data <= {bus.rd_addr, 24'(rd_val)};
    end
  end
`else
  logic unused_rd;

  assign bus.rd_valid = 1'b0;
  assign bus.rd_data  = '0;
  assign unused_rd    = ^{bus.rd_addr, bus.rd_req};
`endif

  tlm_serializer #(
    .TLM_BITS (TLM_BITS)
  ) u_tlm (
    .clk         (clk),
    .rst         (rst),
    .tlm_in      (tlm_in),
    .tlm_capture (tlm_capture),
    .tlm_data    (bus.tlm_data),
    .tlm_valid   (bus.tlm_valid),
    .tlm_ready   (bus.tlm_ready),
    .tlm_busy    (tlm_busy),
    .tlm_overrun (tlm_overrun)
  );

endmodule

// File: tb/tb_regmap_stream.sv
// tb_regmap_stream: directed plus randomized bench for regmap_stream with a
// behavioural model of the register file and the telemetry beat sequence.
module tb_regmap_stream;
  import regmap_pkg::*;

  localparam int NUM_REGS = 32;
  localparam int DATA_W   = 24;
  localparam int TLM_BITS = 120;
  localparam int RW       = NUM_REGS * DATA_W;
  localparam logic [RW-1:0] RV = (RW'(24'd95000)   << (16 * DATA_W))
                               | (RW'(24'h00ABCD)  << (3 * DATA_W))
                               | (RW'(24'hA5A5A5)  << (31 * DATA_W));
`ifdef REGMAP_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  logic                clk;
  logic                rst;
  logic [RW-1:0]       regs_q;
  logic [NUM_REGS-1:0] wr_strobe;
  logic                wr_err;
  logic [TLM_BITS-1:0] tlm_in;
  logic                tlm_capture;
  logic                tlm_busy;
  logic [7:0]          tlm_overrun;

  regmap_stream_if bus ();

  regmap_stream #(
    .NUM_REGS   (NUM_REGS),
    .DATA_W     (DATA_W),
    .RESET_VALS (RV),
    .TLM_BITS   (TLM_BITS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .regs_q      (regs_q),
    .wr_strobe   (wr_strobe),
    .wr_err      (wr_err),
    .tlm_in      (tlm_in),
    .tlm_capture (tlm_capture),
    .tlm_busy    (tlm_busy),
    .tlm_overrun (tlm_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [23:0] mregs [NUM_REGS];
  logic [31:0] rd_hold;
  logic [63:0] exp_beats [$];
  int          ovr_exp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) mregs[i] = RV[i*DATA_W +: DATA_W];
    rd_hold = '0;
    exp_beats.delete();
    ovr_exp = 0;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NUM_REGS; i++)
      check($sformatf("%s.reg%0d", tag, i), 64'(regs_q[i*DATA_W +: DATA_W]), 64'(mregs[i]));
  endtask

  // One bus cycle: drive write/read, predict, advance, compare.
  task automatic do_cycle(input logic wv, input logic [31:0] wd, input logic rq,
                          input logic [7:0] ra, input string tag);
    logic [7:0]  wa;
    bit          wok, rok;
    logic [31:0] exp_strobe;
    logic        exp_err;
    wa  = wd[31:24];
    wok = (wa != 8'd0) && (int'(wa) < NUM_REGS);
    rok = (ra != 8'd0) && (int'(ra) < NUM_REGS);
    exp_strobe = (wv && wok) ? (32'd1 << wa) : 32'd0;
    exp_err    = wv && !wok;
    if (rq) rd_hold = {ra, rok ? mregs[ra[4:0]] : 24'h0};
    if (wv && wok) mregs[wa[4:0]] = wd[23:0];
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.rd_req   = rq;
    bus.rd_addr  = ra;
    tick();
    check($sformatf("%s.strobe", tag), 64'(wr_strobe), 64'(exp_strobe));
    check($sformatf("%s.err", tag), 64'(wr_err), 64'(exp_err));
    check($sformatf("%s.rd_valid", tag), 64'(bus.rd_valid), 64'(RB_EN && rq));
    check($sformatf("%s.rd_data", tag), 64'(bus.rd_data), RB_EN ? 64'(rd_hold) : 64'd0);
    if (wv && wok)
      check($sformatf("%s.wreg", tag), 64'(regs_q[int'(wa)*DATA_W +: DATA_W]), 64'(wd[23:0]));
    bus.wr_valid = 1'b0;
    bus.rd_req   = 1'b0;
  endtask

  // Expected beat k of a snapshot: 60 bits taken MSB-first, tag k+1.
  function automatic logic [63:0] exp_beat(input logic [TLM_BITS-1:0] snap, input int k);
    logic [TLM_BITS-1:0] t;
    t = snap >> (TLM_BITS - 60 * (k + 1));
    return {4'(k + 1), t[59:0]};
  endfunction

  // One telemetry cycle: predict handshake/capture outcome, advance, compare.
  task automatic tlm_cycle(input logic cap, input logic rdy, input string tag);
    if (exp_beats.size() > 0) begin
      if (cap) ovr_exp = (ovr_exp < 255) ? ovr_exp + 1 : 255;
      if (rdy) void'(exp_beats.pop_front());
    end else if (cap) begin
      for (int k = 0; k < (TLM_BITS + 59) / 60; k++) exp_beats.push_back(exp_beat(tlm_in, k));
    end
    tlm_capture   = cap;
    bus.tlm_ready = rdy;
    tick();
    check($sformatf("%s.valid", tag), 64'(bus.tlm_valid), 64'(exp_beats.size() > 0));
    check($sformatf("%s.busy", tag), 64'(tlm_busy), 64'(exp_beats.size() > 0));
    check($sformatf("%s.overrun", tag), 64'(tlm_overrun), 64'(ovr_exp));
    if (exp_beats.size() > 0)
      check($sformatf("%s.data", tag), bus.tlm_data, exp_beats[0]);
    tlm_capture = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.wr_data   = '0;
    bus.wr_valid  = 1'b0;
    bus.rd_addr   = '0;
    bus.rd_req    = 1'b0;
    bus.tlm_ready = 1'b0;
    tlm_in        = '0;
    tlm_capture   = 1'b0;
    model_reset();
    tick();
    tick();

    // Reset state.
    check("rst.strobe", 64'(wr_strobe), 64'd0);
    check("rst.err", 64'(wr_err), 64'd0);
    check("rst.rd_valid", 64'(bus.rd_valid), 64'd0);
    check("rst.rd_data", 64'(bus.rd_data), 64'd0);
    check("rst.tlm_valid", 64'(bus.tlm_valid), 64'd0);
    check("rst.tlm_busy", 64'(tlm_busy), 64'd0);
    check("rst.tlm_data", bus.tlm_data, 64'd0);
    check("rst.overrun", 64'(tlm_overrun), 64'd0);
    check_regs("rst");
    rst = 1'b0;

    // Reset readback of slot 0x10 (95000).
    do_cycle(1'b0, 32'h0, 1'b1, ADDR_MAX_SPEED, "rdrst");
    check("rdrst.lit", 64'(bus.rd_data), RB_EN ? 64'h10017318 : 64'd0);
    do_cycle(1'b0, 32'h0, 1'b0, 8'h00, "rdhold");

    // Write to 0x0B, strobe pulses exactly once.
    do_cycle(1'b1, 32'h0B00FFF6, 1'b0, 8'h00, "wr");
    check("wr.lit_reg", 64'(regs_q[11*DATA_W +: DATA_W]), 64'h00FFF6);
    check("wr.lit_strobe", 64'(wr_strobe), 64'h800);
    do_cycle(1'b0, 32'h0, 1'b0, 8'h00, "wr_after");

    // Invalid addresses: NUM_REGS and the reserved 0.
    do_cycle(1'b1, 32'h20000001, 1'b0, 8'h00, "bad32");
    check_regs("bad32");
    do_cycle(1'b1, 32'h00123456, 1'b1, 8'h00, "bad0");
    check_regs("bad0");
    do_cycle(1'b0, 32'h0, 1'b1, 8'hC8, "rdbad");

    // Read-during-write returns the old value.
    do_cycle(1'b1, 32'h12000005, 1'b1, ADDR_KP, "rdw");
    check("rdw.lit", 64'(bus.rd_data), RB_EN ? 64'h12000000 : 64'd0);
    do_cycle(1'b0, 32'h0, 1'b1, ADDR_KP, "rdw2");
    check("rdw2.lit", 64'(bus.rd_data), RB_EN ? 64'h12000005 : 64'd0);

    // Random register traffic.
    for (int n = 0; n < 80; n++)
      do_cycle(1'($urandom_range(0, 1)), {8'($urandom_range(0, 40)), 24'($urandom)},
               1'($urandom_range(0, 1)), 8'($urandom_range(0, 40)), $sformatf("rnd%0d", n));
    check_regs("rnd_end");

    // Stalled snapshot: beat 1 held for 3 cycles, then beat 2, then idle.
    tlm_in = 120'h23456789ABCDEF0123456789ABCDEF;
    tlm_cycle(1'b1, 1'b0, "stall_cap");
    for (int n = 0; n < 3; n++) tlm_cycle(1'b0, 1'b0, "stall_hold");
    check("stall.beat1", bus.tlm_data, 64'h123456789ABCDEF0);
    tlm_in = '0;
    tlm_cycle(1'b0, 1'b1, "stall_b2");
    check("stall.beat2", bus.tlm_data, 64'h2123456789ABCDEF);
    tlm_cycle(1'b0, 1'b1, "stall_idle");

    // Overrun: two drops mid-snapshot, one on the last handshake, then back-to-back capture.
    tlm_in = {$urandom, $urandom, $urandom, 24'($urandom)};
    tlm_cycle(1'b1, 1'b0, "ovr_cap");
    tlm_cycle(1'b1, 1'b0, "ovr_d1");
    tlm_cycle(1'b0, 1'b0, "ovr_w");
    tlm_cycle(1'b1, 1'b0, "ovr_d2");
    check("ovr.two", 64'(tlm_overrun), 64'd2);
    tlm_cycle(1'b0, 1'b1, "ovr_b1");
    tlm_cycle(1'b1, 1'b1, "ovr_last");
    check("ovr.last", 64'(tlm_overrun), 64'd3);
    tlm_cycle(1'b1, 1'b1, "b2b_cap");
    check("b2b.tag", 64'(bus.tlm_data[63:60]), 64'd1);
    tlm_cycle(1'b0, 1'b1, "b2b_b2");
    tlm_cycle(1'b0, 1'b1, "b2b_idle");

    // Random snapshots with random sink back-pressure.
    for (int n = 0; n < 200; n++) begin
      tlm_in = {$urandom, $urandom, $urandom, 24'($urandom)};
      tlm_cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), $sformatf("trnd%0d", n));
    end
    for (int n = 0; n < 4; n++) tlm_cycle(1'b0, 1'b1, "tdrain");

    // Saturation: 300 dropped captures.
    tlm_cycle(1'b1, 1'b0, "sat_cap");
    for (int n = 0; n < 300; n++) tlm_cycle(1'b1, 1'b0, "sat");
    check("sat.255", 64'(tlm_overrun), 64'd255);
    tlm_cycle(1'b0, 1'b1, "sat_b2");

    // Reset mid-snapshot aborts it.
    tlm_in = 120'hFEDCBA9876543210FEDCBA98765432;
    rst = 1'b1;
    model_reset();
    tick();
    check("mrst.valid", 64'(bus.tlm_valid), 64'd0);
    check("mrst.busy", 64'(tlm_busy), 64'd0);
    check("mrst.data", bus.tlm_data, 64'd0);
    check("mrst.overrun", 64'(tlm_overrun), 64'd0);
    check("mrst.rd_data", 64'(bus.rd_data), 64'd0);
    check_regs("mrst");
    rst = 1'b0;
    tlm_cycle(1'b1, 1'b1, "mrst_cap");
    rst = 1'b1;
    exp_beats.delete();
    tick();
    rst = 1'b0;
    for (int n = 0; n < 3; n++) tlm_cycle(1'b0, 1'b1, "mrst_quiet");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
